uart_rx_engine: RTL

//  UART receiver: the receive end of the link driven by the UART transmit datapath.
//  - Synchronises the serial rx pin and detects the start bit.
//  - Mid-bit samples 5..8 data bits (LSB first), an optional parity bit and the stop bit.
//  - Presents each frame as a parallel word with error flags, via a valid/ready handshake.
//  - Sits between the rx pad and the UART CSR/FIFO logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_engine.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, line-level constants and receive FSM encoding
package uart_pkg;

    typedef logic [7:0] uart_data_t;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } uart_rx_state_t;

    // Only 5..8 data bits form a legal frame; anything else keeps the receiver idle.
    function automatic logic data_bits_ok(input logic [3:0] n);
        return (n >= 4'd5) && (n <= 4'd8);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-flop synchroniser for the asynchronous rx line
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   rx         : raw serial line from the pad
//   rx_s       : synchronised line; resets to 1 so the idle line shows no fall
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receiver: start detect, mid-bit sampling, word delivery
// Ports:
//   clk, rst_n             : clock and asynchronous active-low reset
//   rx                     : serial line (idle 1)
//   rx_en                  : receiver enable; dropping it mid-frame aborts the frame
//   baud_count             : clocks per bit period (>=4)
//   data_bits              : 5..8 data bits per frame
//   parity_en, odd_parity  : parity configuration
//   rx_data, rx_valid      : received word, held until rx_ready
//   rx_ready               : consumer accept
//   parity_err, frame_err  : error flags for the held word
//   overrun_err            : 1-cycle pulse when a frame is dropped because the held word was not taken
//   busy                   : receive FSM not idle
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_en,
    input  logic [CNT_WIDTH-1:0] baud_count,
    input  logic [3:0]           data_bits,
    input  logic                 parity_en,
    input  logic                 odd_parity,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    uart_rx_state_t state, state_nxt;

    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    logic                 start_ok;
    logic                 abort;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 tick;
    logic [3:0]           bit_idx;
    logic                 last_data;
    uart_data_t           shift;
    logic [3:0]           cfg_bits;
    logic                 cfg_par;
    logic                 cfg_odd;
    logic                 perr_n;
    logic                 ferr_n;
    logic                 frame_done;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    assign fall      = rx_prev & ~rx_s;
    assign start_ok  = fall & rx_en & data_bits_ok(data_bits);
    assign abort     = (state != RX_IDLE) & ~rx_en;
    assign tick      = (cnt == '0);
    assign last_data = (bit_idx == (cfg_bits - 4'd1));
    assign busy      = (state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:   if (start_ok) state_nxt = RX_START;
            RX_START:  if (tick) state_nxt = (rx_s == UART_START_BIT) ? RX_DATA : RX_IDLE;
            RX_DATA:   if (tick && last_data) state_nxt = cfg_par ? RX_PARITY : RX_STOP;
            RX_PARITY: if (tick) state_nxt = RX_STOP;
            RX_STOP:   if (tick) state_nxt = RX_IDLE;
            default:   state_nxt = RX_IDLE;
        endcase
        if (abort) state_nxt = RX_IDLE;
    end

    // Bit-period counter, sampling datapath and frame configuration latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            cfg_bits   <= 4'd8;
            cfg_par    <= 1'b0;
            cfg_odd    <= 1'b0;
            perr_n     <= 1'b0;
            ferr_n     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!abort) begin
                case (state)
                    RX_IDLE: begin
                        if (start_ok) begin
                            // Half a period lands the start-bit check mid-bit.
                            cnt      <= baud_count >> 1;
                            cfg_bits <= data_bits;
                            cfg_par  <= parity_en;
                            cfg_odd  <= odd_parity;
                        end
                    end
                    RX_START: begin
                        if (tick) begin
                            cnt     <= baud_count - CNT_ONE;
                            bit_idx <= '0;
                            shift   <= '0;
                            perr_n  <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    RX_DATA: begin
                        if (tick) begin
                            shift[bit_idx[2:0]] <= rx_s;
                            bit_idx             <= bit_idx + 4'd1;
                            cnt                 <= baud_count - CNT_ONE;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    RX_PARITY: begin
                        if (tick) begin
                            // Unused upper shift bits are zero, so they do not disturb the XOR.
                            perr_n <= rx_s ^ (^shift) ^ cfg_odd;
                            cnt    <= baud_count - CNT_ONE;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    RX_STOP: begin
                        if (tick) begin
                            ferr_n     <= (rx_s != UART_STOP_BIT);
                            frame_done <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

    // Output holding register: a completed frame loads only if the slot is free
    // or being emptied this same cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data    <= shift;
                parity_err <= perr_n;
                frame_err  <= ferr_n;
                rx_valid   <= 1'b1;
            end else begin
                if (frame_done) overrun_err <= 1'b1;
                if (rx_valid && rx_ready) rx_valid <= 1'b0;
            end
        end
    end

endmodule
